demux1to4_seq: RTL and testbench

Clocked 1-to-N demultiplexer that steers a single data bit onto one of N output lanes. It is the steering counterpart of the 2:1 RC mux: the mux selects one of several sources onto one line, and this block routes one source onto a selected line. It sits between a spike or event source and the per-lane RC gate models. Each request is accepted by a valid/ready handshake, driven as a registered pulse of fixed length and followed by a break-before-make gap, so two lanes never switch in the same cycle.

---
 rtl/demux1to4_seq_if.sv | 25 ++
 rtl/demux1to4_seq.sv | 123 ++++++++++++
 tb/tb_demux1to4_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux1to4_seq_if.sv
// Request/lane bundle between an event source and demux1to4_seq.
// Source drives the request side; the demux drives lanes and status.
// No state of its own; flow control is the in_valid/in_ready pair.
interface demux1to4_seq_if #(
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             d;
  logic [N_OUT-1:0] y;
  logic             busy;
  logic             err;

  modport master (
    output in_valid, sel, d,
    input  in_ready, y, busy, err
  );

  modport slave (
    input  in_valid, sel, d,
    output in_ready, y, busy, err
  );
endinterface

// File: rtl/demux1to4_seq.sv
// Steers one data bit onto one of N_OUT lanes as a PULSE_LEN pulse + GAP_LEN gap (DEMUX_HOLD_EN: latch lane).
// Latency: y registered, valid the cycle after the accepting edge; one request per PULSE_LEN+GAP_LEN+1 cycles.
// Backpressure: in_ready low outside IDLE; requests are ignored until it returns high.
module demux1to4_seq #(
  parameter int N_OUT     = 4,
  parameter int SEL_W     = 2,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  demux1to4_seq_if.slave   bus
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel_q;
  logic             r_d_q;
  logic [N_OUT-1:0] r_y;
  logic             r_err;

  logic             w_sel_ok;
  logic [N_OUT-1:0] w_lane;
  logic [N_OUT-1:0] w_lane_q;

  assign w_sel_ok = (int'(bus.sel) < N_OUT);
  assign w_lane   = {{(N_OUT-1){1'b0}}, bus.d} << bus.sel;
  assign w_lane_q = {{(N_OUT-1){1'b0}}, r_d_q} << r_sel_q;

  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.y        = r_y;
  assign bus.err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel_q <= '0;
      r_d_q   <= 1'b0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_sel_ok) begin
              r_sel_q <= bus.sel;
              r_d_q   <= bus.d;
`ifdef DEMUX_HOLD_EN
              // Switching away from the latched lane still needs the dead gap.
              if ((bus.sel != r_sel_q) && (GAP_LEN > 0)) begin
                r_y     <= '0;
                r_cnt   <= G_LOAD;
                r_state <= S_GAP;
              end else begin
                r_y     <= w_lane;
                r_cnt   <= P_LOAD;
                r_state <= S_DRIVE;
              end
`else
              r_y     <= w_lane;
              r_cnt   <= P_LOAD;
              r_state <= S_DRIVE;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_DRIVE: begin
          r_y <= w_lane_q;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
`ifdef DEMUX_HOLD_EN
            r_state <= S_IDLE;
`else
            r_y <= '0;
            if (GAP_LEN > 0) begin
              r_cnt   <= G_LOAD;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
`endif
          end
        end

        S_GAP: begin
          r_y <= '0;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
`ifdef DEMUX_HOLD_EN
            // Gap only precedes a lane change here, so the pulse follows.
            r_y     <= w_lane_q;
            r_cnt   <= P_LOAD;
            r_state <= S_DRIVE;
`else
            r_state <= S_IDLE;
`endif
          end
        end

        default: begin
          r_y     <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux1to4_seq.sv
// Bench for demux1to4_seq: schedule-based reference model checked every cycle plus directed literal checks.
module tb_demux1to4_seq;
`ifdef DEMUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  demux1to4_seq_if #(.N_OUT(4), .SEL_W(3)) b0 ();
  demux1to4_seq_if #(.N_OUT(4), .SEL_W(2)) b1 ();

  demux1to4_seq #(.N_OUT(4), .SEL_W(3), .PULSE_LEN(2), .GAP_LEN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  demux1to4_seq #(.N_OUT(4), .SEL_W(2), .PULSE_LEN(1), .GAP_LEN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each accepted request appends its future per-cycle lane values
  // to a schedule; every edge consumes one entry, and the block is busy exactly
  // while entries are being consumed.
  logic [3:0] m_sched [2][8];
  int         m_len   [2];
  bit         m_busy  [2];
  logic [3:0] m_y     [2];
  bit         m_err   [2];
  int         m_last  [2];

  task automatic push(input int id, input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      m_sched[id][m_len[id]] = v;
      m_len[id]++;
    end
  endtask

  task automatic m_edge(input int id, input int p, input int g,
                        input bit v, input int s, input bit dd);
    logic [3:0] oh;
    m_err[id] = 1'b0;
    if (!m_busy[id] && v) begin
      if (s < 4) begin
        oh = dd ? (4'b0001 << s) : 4'b0000;
        if (HOLD && (s == m_last[id] || g == 0)) push(id, oh, p);
        else if (HOLD) begin push(id, 4'b0, g); push(id, oh, p); end
        else begin push(id, oh, p); push(id, 4'b0, g); end
        m_last[id] = s;
      end else begin
        m_err[id] = 1'b1;
      end
    end
    if (m_len[id] > 0) begin
      m_y[id] = m_sched[id][0];
      for (int i = 0; i < 7; i++) m_sched[id][i] = m_sched[id][i+1];
      m_len[id]--;
      m_busy[id] = 1'b1;
    end else begin
      m_busy[id] = 1'b0;
      if (!HOLD) m_y[id] = 4'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_len[k] = 0; m_busy[k] = 1'b0; m_y[k] = 4'b0; m_err[k] = 1'b0; m_last[k] = 0;
      end
    end else begin
      m_edge(0, 2, 1, b0.in_valid, int'(b0.sel), b0.d);
      m_edge(1, 1, 0, b1.in_valid, int'(b1.sel), b1.d);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_y0",    b0.y,        m_y[0]);
      chk("model_rdy0",  b0.in_ready, !m_busy[0]);
      chk("model_busy0", b0.busy,     m_busy[0]);
      chk("model_err0",  b0.err,      m_err[0]);
      chk("onehot0",     ($countones(b0.y) <= 1), 1);
      chk("model_y1",    b1.y,        m_y[1]);
      chk("model_rdy1",  b1.in_ready, !m_busy[1]);
      chk("model_busy1", b1.busy,     m_busy[1]);
      chk("model_err1",  b1.err,      m_err[1]);
      chk("onehot1",     ($countones(b1.y) <= 1), 1);
    end
  end

  logic [3:0] tab [7];

  initial begin
    b0.in_valid = 1'b0; b0.sel = '0; b0.d = 1'b0;
    b1.in_valid = 1'b0; b1.sel = '0; b1.d = 1'b0;
    tab = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_y0", b0.y, 4'b0);
    chk("rst_busy0", b0.busy, 0);
    chk("rst_err0", b0.err, 0);
    chk("rst_y1", b1.y, 4'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy0", b0.in_ready, 1);
    chk("rst_rdy1", b1.in_ready, 1);
    @(negedge clk);

    // Out-of-range select: dropped, one-cycle err
    b0.in_valid = 1'b1; b0.sel = 3'd5; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    chk("err_hi", b0.err, 1);
    chk("err_y", b0.y, 4'b0);
    chk("err_rdy", b0.in_ready, 1);
    @(negedge clk);
    chk("err_lo", b0.err, 0);

    // Reset during a lane-2 pulse clears y without a clock edge
    b0.in_valid = 1'b1; b0.sel = 3'd2; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    for (int i = 0; i < 4 && b0.y != 4'b0100; i++) @(negedge clk);
    chk("arst_drive_y", b0.y, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", b0.y, 4'b0);
    chk("arst_busy", b0.busy, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("arst_rdy", b0.in_ready, 1);
    @(negedge clk);
    chk("arst_no_resume_y", b0.y, 4'b0);
    chk("arst_no_resume_busy", b0.busy, 0);

    // PULSE_LEN=1, GAP_LEN=0, d=0: one busy cycle, y stays low
    b1.in_valid = 1'b1; b1.sel = 2'd0; b1.d = 1'b0;
    @(negedge clk); b1.in_valid = 1'b0;
    chk("g0_y", b1.y, 4'b0);
    chk("g0_busy", b1.busy, 1);
    chk("g0_rdy", b1.in_ready, 0);
    @(negedge clk);
    chk("g0_busy_end", b1.busy, 0);
    chk("g0_rdy_back", b1.in_ready, 1);

`ifndef DEMUX_HOLD_EN
    // Single pulse on lane 2, then next accept four cycles later
    b0.in_valid = 1'b1; b0.sel = 3'd2; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    chk("p_y1", b0.y, 4'b0100); chk("p_rdy1", b0.in_ready, 0);
    @(negedge clk);
    chk("p_y2", b0.y, 4'b0100); chk("p_rdy2", b0.in_ready, 0);
    @(negedge clk);
    chk("p_gap_y", b0.y, 4'b0000); chk("p_gap_rdy", b0.in_ready, 0);
    @(negedge clk);
    chk("p_idle_rdy", b0.in_ready, 1);
    b0.in_valid = 1'b1; b0.sel = 3'd0; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    chk("p_next_y", b0.y, 4'b0001);
    repeat (4) @(negedge clk);

    // Back-to-back sel=1 then sel=3 with valid held high
    b0.in_valid = 1'b1; b0.sel = 3'd1; b0.d = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_y%0d", i), b0.y, tab[i]);
      if (i == 0) b0.sel = 3'd3;
      if (i == 4) b0.in_valid = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Zero gap: lane returns low the next cycle
    b1.in_valid = 1'b1; b1.sel = 2'd3; b1.d = 1'b1;
    @(negedge clk); b1.in_valid = 1'b0;
    chk("g0_lane3_y", b1.y, 4'b1000);
    @(negedge clk);
    chk("g0_lane3_off", b1.y, 4'b0000);
    chk("g0_lane3_rdy", b1.in_ready, 1);
`else
    // Latched lane 1
    b0.in_valid = 1'b1; b0.sel = 3'd1; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("h_latched_y", b0.y, 4'b0010);
    chk("h_latched_busy", b0.busy, 0);
    // Same lane, d=0: no gap, busy for the pulse only
    b0.in_valid = 1'b1; b0.sel = 3'd1; b0.d = 1'b0;
    @(negedge clk); b0.in_valid = 1'b0;
    chk("h_same_y", b0.y, 4'b0000);
    chk("h_same_busy", b0.busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("h_same_rdy", b0.in_ready, 1);
    // Different lane: one dead cycle, then lane 3 latched
    b0.in_valid = 1'b1; b0.sel = 3'd3; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    chk("h_diff_gap_y", b0.y, 4'b0000);
    chk("h_diff_gap_busy", b0.busy, 1);
    @(negedge clk);
    chk("h_diff_y", b0.y, 4'b1000);
    repeat (3) @(negedge clk);
    chk("h_diff_latched_y", b0.y, 4'b1000);
    // err request leaves the held lane untouched
    b0.in_valid = 1'b1; b0.sel = 3'd6; b0.d = 1'b1;
    @(negedge clk); b0.in_valid = 1'b0;
    chk("h_err_hi", b0.err, 1);
    chk("h_err_y", b0.y, 4'b1000);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
